// File: rtl/seq_alarm.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alarm
//  Description : Symbol-sequence detector with alarm output, failed-attempt
//                counting and a timed lockout after too many broken attempts.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alarm #(
  parameter int                       SYM_W    = 2,
  parameter int                       SEQ_LEN  = 3,
  parameter logic [SYM_W*SEQ_LEN-1:0] SEQ      = 6'b11_10_01,
  parameter int                       STICKY   = 1,
  parameter int                       MAX_FAIL = 3,
  parameter int                       LOCK_CYC = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           sym_valid,
  input  logic [SYM_W-1:0]               sym,
  input  logic                           clr,
  output logic                           alarm,
  output logic [$clog2(SEQ_LEN+1)-1:0]   progress,
  output logic [3:0]                     fail_cnt,
  output logic                           locked
);

  localparam int                PW          = $clog2(SEQ_LEN+1);
  localparam int                c_depth     = 1 << PW;
  localparam logic [PW-1:0]     c_last      = PW'(SEQ_LEN-1);
  localparam logic [3:0]        c_fail_last = 4'(MAX_FAIL-1);
  localparam logic [7:0]        c_lock_cyc  = 8'(LOCK_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HIT   = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_alarm;
  logic [PW-1:0]     r_progress;
  logic [3:0]        r_fail_cnt;
  logic              r_locked;
  logic [7:0]        r_lock_cnt;

  // Sequence elements unpacked into a power-of-two table so that the
  // progress register can index it directly; padding entries are never used.
  logic [SYM_W-1:0]  w_elem [c_depth];

  for (genvar k = 0; k < c_depth; k++) begin : g_elem
    if (k < SEQ_LEN) begin : g_used
      assign w_elem[k] = SEQ[SYM_W*k +: SYM_W];
    end else begin : g_pad
      assign w_elem[k] = '0;
    end
  end

  logic w_match;
  logic w_first;
  assign w_match = (sym == w_elem[r_progress]);
  assign w_first = (sym == w_elem[0]);

  // Detector FSM: tracks matched elements, counts broken attempts, times the
  // lockout and drives the registered alarm.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_alarm    <= 1'b0;
      r_progress <= '0;
      r_fail_cnt <= 4'd0;
      r_locked   <= 1'b0;
      r_lock_cnt <= 8'd0;
    end else begin
      // Sticky alarm holds until acknowledged; pulse mode self-clears.
      // A completion further down overrides this (completion beats clr).
      if (STICKY != 0) begin
        if (clr) begin
          r_alarm <= 1'b0;
        end
      end else begin
        r_alarm <= 1'b0;
      end

      case (r_state)
        ST_IDLE, ST_TRACK: begin
          if (sym_valid) begin
            if (w_match) begin
              if (r_progress == c_last) begin
                r_alarm    <= 1'b1;
                r_progress <= '0;
                r_fail_cnt <= 4'd0;
                r_state    <= ST_HIT;
              end else begin
                r_progress <= r_progress + PW'(1);
                r_state    <= ST_TRACK;
              end
            end else if (r_progress != '0) begin
              if (r_fail_cnt == c_fail_last) begin
                // Too many broken attempts: lock out, pending alarm survives.
                r_state    <= ST_LOCK;
                r_locked   <= 1'b1;
                r_progress <= '0;
                r_fail_cnt <= 4'd0;
                r_lock_cnt <= c_lock_cyc;
              end else begin
                r_fail_cnt <= r_fail_cnt + 4'd1;
                // The breaking symbol may itself start a new attempt.
                r_progress <= w_first ? PW'(1) : '0;
                r_state    <= w_first ? ST_TRACK : ST_IDLE;
              end
            end
          end
        end
        ST_HIT: begin
          r_state <= ST_IDLE;
        end
        ST_LOCK: begin
          if (r_lock_cnt == 8'd1) begin
            r_state    <= ST_IDLE;
            r_locked   <= 1'b0;
            r_lock_cnt <= 8'd0;
          end else begin
            r_lock_cnt <= r_lock_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alarm    = r_alarm;
  assign progress = r_progress;
  assign fail_cnt = r_fail_cnt;
  assign locked   = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_seq_alarm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alarm
//  Description : Scoreboard bench for seq_alarm; two instances (sticky with
//                default lockout, pulse mode with short lockout) share one
//                stimulus stream and are compared against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_alarm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       sym_valid;
  logic [1:0] sym;
  logic       clr;

  logic       a0, a1, l0, l1;
  logic [1:0] p0, p1;
  logic [3:0] f0, f1;

  always #5 CLK = ~CLK;

  seq_alarm dut0 (
    .CLK(CLK), .RST(RST), .sym_valid(sym_valid), .sym(sym), .clr(clr),
    .alarm(a0), .progress(p0), .fail_cnt(f0), .locked(l0)
  );

  seq_alarm #(.STICKY(0), .MAX_FAIL(2), .LOCK_CYC(3)) dut1 (
    .CLK(CLK), .RST(RST), .sym_valid(sym_valid), .sym(sym), .clr(clr),
    .alarm(a1), .progress(p1), .fail_cnt(f1), .locked(l1)
  );

  // Abstract model state: how far into the sequence, how many failures,
  // how many lockout cycles remain, and whether a completion just happened.
  typedef struct {
    int prog;
    int fail;
    int lock_left;
    bit hit;
    bit alarm;
  } mdl_t;

  typedef struct {
    mdl_t m0;
    mdl_t m1;
  } exp_t;

  exp_t q[$];
  mdl_t s0, s1;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic mdl_t step(mdl_t m, bit rstn, bit v, int s, bit c,
                                bit sticky, int maxf, int lockc);
    mdl_t n;
    int   seq_el[3];
    seq_el = '{1, 2, 3};
    if (!rstn) begin
      n = '{default: 0};
      return n;
    end
    n       = m;
    n.hit   = 1'b0;
    n.alarm = sticky ? (m.alarm && !c) : 1'b0;
    if (m.lock_left > 0) begin
      n.lock_left = m.lock_left - 1;
    end else if (m.hit) begin
      // completion cycle: input not considered
    end else if (v) begin
      if (s == seq_el[m.prog]) begin
        if (m.prog + 1 == 3) begin
          n.prog = 0; n.fail = 0; n.hit = 1'b1; n.alarm = 1'b1;
        end else begin
          n.prog = m.prog + 1;
        end
      end else if (m.prog > 0) begin
        if (m.fail + 1 == maxf) begin
          n.lock_left = lockc; n.prog = 0; n.fail = 0;
        end else begin
          n.fail = m.fail + 1;
          n.prog = (s == seq_el[0]) ? 1 : 0;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic cyc(input bit rstn, input bit v, input int s, input bit c);
    exp_t e;
    RST       = rstn;
    sym_valid = v;
    sym       = 2'(s);
    clr       = c;
    s0 = step(s0, rstn, v, s, c, 1'b1, 3, 8);
    s1 = step(s1, rstn, v, s, c, 1'b0, 2, 3);
    e.m0 = s0;
    e.m1 = s1;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic sy(input int s);
    cyc(1'b1, 1'b1, s, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per edge.
  always begin
    exp_t e;
    @(posedge CLK);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("alarm0",    32'(a0), 32'(e.m0.alarm));
      chk("progress0", 32'(p0), 32'(e.m0.prog));
      chk("fail_cnt0", 32'(f0), 32'(e.m0.fail));
      chk("locked0",   32'(l0), 32'(e.m0.lock_left > 0));
      chk("alarm1",    32'(a1), 32'(e.m1.alarm));
      chk("progress1", 32'(p1), 32'(e.m1.prog));
      chk("fail_cnt1", 32'(f1), 32'(e.m1.fail));
      chk("locked1",   32'(l1), 32'(e.m1.lock_left > 0));
    end
  end

  initial begin
    bit v;
    // reset state
    cyc(1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b1, 1, 1'b0);
    // clean sequence
    sy(1); sy(2); sy(3); idle(2);
    // restart on repeated first symbol
    cyc(1'b1, 1'b0, 0, 1'b1);
    sy(1); sy(1); sy(2); sy(3); idle(2);
    // three broken attempts, then sequence during lockout
    cyc(1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin sy(1); sy(0); end
    sy(1); sy(2); sy(3);
    idle(10);
    // clr coincident with completion, then clr alone
    sy(1); sy(2);
    cyc(1'b1, 1'b1, 3, 1'b1);
    cyc(1'b1, 1'b0, 0, 1'b1);
    idle(1);
    // reset mid-sequence
    sy(1); sy(2);
    cyc(1'b0, 1'b0, 0, 1'b0);
    sy(2); sy(3); idle(1);
    // reset mid-lockout
    for (int i = 0; i < 3; i++) begin sy(1); sy(0); end
    idle(2);
    cyc(1'b0, 1'b1, 1, 1'b0);
    sy(2); sy(3); idle(1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7) && !s0.hit && !s1.hit;
      cyc(($urandom_range(0, 99) != 0), v, int'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0));
    end
    idle(3);
    repeat (2) @(posedge CLK);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alarm.md
SEQ_ALARM -- requirements
Module: seq_alarm

Interface
REQ-001 The block SHALL provide parameter SYM_W, default 2, meaning input symbol width in bits (1..8).
REQ-002 The block SHALL provide parameter SEQ_LEN, default 3, meaning number of symbols in the armed sequence (2..8).
REQ-003 The block SHALL provide parameter SEQ, default 6'b11_10_01, meaning packed sequence; element k = SEQ[SYM_W*k +: SYM_W], k=0 expected first.
REQ-004 The block SHALL provide parameter STICKY, default 1, meaning 1 = alarm held until clr, 0 = one-cycle alarm pulse.
REQ-005 The block SHALL provide parameter MAX_FAIL, default 3, meaning number of broken attempts that triggers lockout (1..15).
REQ-006 The block SHALL provide parameter LOCK_CYC, default 8, meaning lockout duration in CLK cycles (1..255).
REQ-007 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port RST, input, 1 bit; reset is synchronous and active-low.
REQ-009 The block SHALL have port sym_valid, input, 1 bit, qualifying sym for the current cycle.
REQ-010 The block SHALL have port sym, input, SYM_W bits, the lamp/switch symbol.
REQ-011 The block SHALL have port clr, input, 1 bit, alarm acknowledge.
REQ-012 The block SHALL have port alarm, output, 1 bit, the LED drive.
REQ-013 The block SHALL have port progress, output, clog2(SEQ_LEN+1) bits, number of sequence elements currently matched.
REQ-014 The block SHALL have port fail_cnt, output, 4 bits, broken attempts since the last success or lockout.
REQ-015 The block SHALL have port locked, output, 1 bit, high while input is ignored.

Function
REQ-016 The block SHALL implement FSM states IDLE (progress=0), TRACK (0<progress<SEQ_LEN), HIT (sequence complete) and LOCK.
REQ-017 In IDLE/TRACK, a cycle with sym_valid=1 and sym==element[progress] SHALL increment progress by one.
REQ-018 When that increment reaches SEQ_LEN, the block SHALL register alarm=1 on the same edge, reset progress to 0, clear fail_cnt, and go to HIT for one cycle, then IDLE.
REQ-019 A mismatching valid symbol with progress>0 SHALL increment fail_cnt; progress SHALL become 1 if sym==element[0], else 0.
REQ-020 A mismatching valid symbol with progress=0 SHALL leave progress and fail_cnt unchanged.
REQ-021 Cycles with sym_valid=0 SHALL not change progress, fail_cnt or FSM state (except LOCK countdown and HIT exit).
REQ-022 When fail_cnt increment reaches MAX_FAIL, the block SHALL enter LOCK on that edge: locked=1, progress=0, fail_cnt=0, load counter with LOCK_CYC.
REQ-023 In LOCK the counter SHALL decrement every cycle; sym_valid SHALL be ignored; LOCK SHALL exit to IDLE (locked=0) after exactly LOCK_CYC cycles with locked high.
REQ-024 With STICKY=1, alarm SHALL stay 1 until a cycle with clr=1, and clear on that edge.
REQ-025 With STICKY=0, alarm SHALL be high for exactly the one cycle following the completing edge; clr SHALL have no effect.
REQ-026 If clr=1 on the same edge as a new completion, alarm SHALL be 1 (completion wins).
REQ-027 Entering LOCK SHALL not clear a pending sticky alarm.
REQ-028 Detection latency SHALL be one cycle: alarm rises on the edge sampling the final valid matching symbol.
REQ-029 Repeated valid symbols SHALL each count as separate events; no edge filtering.

Reset
REQ-030 While RST=0 at a rising CLK edge, the block SHALL set state=IDLE, alarm=0, progress=0, fail_cnt=0, locked=0, lockout counter=0.
REQ-031 Reset SHALL take priority over every other input, including mid-sequence and mid-lockout.
REQ-032 Outputs SHALL be registered; no output SHALL depend combinationally on sym, sym_valid or clr.

Verification
REQ-033 Bench SHALL cover: defaults, valid symbols 01,10,11 -> alarm=1 after third edge, progress 1,2,0, fail_cnt=0.
REQ-034 Bench SHALL cover: defaults, 01,01,10,11 -> second 01 gives progress=1, fail_cnt=1; alarm=1 after 11.
REQ-035 Bench SHALL cover: defaults, three attempts 01,00 -> locked=1 after third 00, high exactly 8 cycles; valid 01,10,11 during lock leaves alarm=0.
REQ-036 Bench SHALL cover: STICKY=1, alarm high, clr=1 together with completing 11 -> alarm stays 1; clr alone next cycle -> alarm=0.
REQ-037 Bench SHALL cover: STICKY=0 -> alarm one-cycle pulse after completion, clr ignored.
REQ-038 Bench SHALL cover: RST=0 asserted with progress=2 and during LOCK -> all outputs 0 on the next edge; 10,11 after release gives no alarm.
